// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-channel TDM receive demultiplexer with frame alignment tracking
module tdm_demux4 #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_valid,
  input  logic           in_sync,
  input  logic [W-1:0]   in_data,
  output logic [W-1:0]   ch_data,
  output logic [3:0]     ch_strobe,
  output logic [4*W-1:0] frame_data,
  output logic           frame_valid,
  output logic           locked,
  output logic [1:0]     sel,
  output logic           sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_d;
  logic [2:0][W-1:0]    stage_q, stage_d;
  logic [W-1:0]         ch_data_d;
  logic [3:0]           ch_strobe_d;
  logic [4*W-1:0]       frame_data_d;
  logic                 frame_valid_d;
  logic                 sync_err_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= HUNT;
      sel         <= '0;
      stage_q     <= '0;
      ch_data     <= '0;
      ch_strobe   <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel         <= sel_d;
      stage_q     <= stage_d;
      ch_data     <= ch_data_d;
      ch_strobe   <= ch_strobe_d;
      frame_data  <= frame_data_d;
      frame_valid <= frame_valid_d;
      sync_err    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel;
    stage_d       = stage_q;
    ch_data_d     = ch_data;
    ch_strobe_d   = 4'b0000;
    frame_data_d  = frame_data;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_sync) begin
            stage_d[0]  = in_data;
            ch_data_d   = in_data;
            ch_strobe_d = 4'b0001;
            sel_d       = 2'd1;
            state_d     = LOCKED;
          end
        end
        default: begin
          if (in_sync) begin
            // A sync anywhere but slot 0 discards the partial frame and restarts it here
            sync_err_d  = (sel != 2'd0);
            stage_d[0]  = in_data;
            ch_data_d   = in_data;
            ch_strobe_d = 4'b0001;
            sel_d       = 2'd1;
          end else if (sel == 2'd0) begin
            sync_err_d  = 1'b1;
            sel_d       = 2'd0;
            state_d     = HUNT;
          end else begin
            ch_data_d   = in_data;
            ch_strobe_d = 4'b0001 << sel;
            sel_d       = 2'(sel + 2'd1);
            case (sel)
              2'd1: stage_d[1] = in_data;
              2'd2: stage_d[2] = in_data;
              default: begin
                frame_data_d  = {in_data, stage_q[2], stage_q[1], stage_q[0]};
                frame_valid_d = 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - self-checking bench for tdm_demux4 with expected-output queue
module tb_tdm_demux4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sync = 1'b0;
  logic [3:0]  in_data = '0;
  logic [3:0]  ch_data;
  logic [3:0]  ch_strobe;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        locked;
  logic [1:0]  sel;
  logic        sync_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  strobe;
    logic        fv;
    logic        err;
    logic        lk;
    logic [1:0]  sel;
    logic [15:0] frame;
    logic [3:0]  ch;
  } exp_t;

  exp_t exp_q[$];

  logic        m_locked;
  logic [1:0]  m_sel;
  logic [3:0]  m_st [4];
  logic [15:0] m_frame;
  logic [3:0]  m_ch;

  tdm_demux4 #(.W(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
    .ch_data(ch_data), .ch_strobe(ch_strobe), .frame_data(frame_data),
    .frame_valid(frame_valid), .locked(locked), .sel(sel), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_sel    = 2'd0;
    m_frame  = '0;
    m_ch     = '0;
    for (int i = 0; i < 4; i++) m_st[i] = '0;
  endtask

  // Drive one cycle, push the model's prediction, then compare after the edge
  task automatic drive(input logic v, input logic s, input logic [3:0] d);
    exp_t e;
    exp_t g;
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    e.strobe = 4'b0000;
    e.fv     = 1'b0;
    e.err    = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1'b1; m_st[0] = d; m_ch = d; e.strobe = 4'b0001; m_sel = 2'd1;
        end
      end else if (s) begin
        e.err = (m_sel != 2'd0); m_st[0] = d; m_ch = d; e.strobe = 4'b0001; m_sel = 2'd1;
      end else if (m_sel == 2'd0) begin
        e.err = 1'b1; m_locked = 1'b0;
      end else begin
        m_ch = d;
        e.strobe = 4'b0001 << m_sel;
        if (m_sel == 2'd3) begin
          m_frame = {d, m_st[2], m_st[1], m_st[0]};
          e.fv = 1'b1;
        end else begin
          m_st[m_sel] = d;
        end
        m_sel = m_sel + 2'd1;
      end
    end
    e.lk    = m_locked;
    e.sel   = m_sel;
    e.frame = m_frame;
    e.ch    = m_ch;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check("ch_strobe", 32'(ch_strobe), 32'(g.strobe));
      check("frame_valid", 32'(frame_valid), 32'(g.fv));
      check("sync_err", 32'(sync_err), 32'(g.err));
      check("locked", 32'(locked), 32'(g.lk));
      check("sel", 32'(sel), 32'(g.sel));
      check("frame_data", 32'(frame_data), 32'(g.frame));
      check("ch_data", 32'(ch_data), 32'(g.ch));
    end
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic frame4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d);
    drive(1'b1, 1'b1, a);
    drive(1'b1, 1'b0, b);
    drive(1'b1, 1'b0, c);
    drive(1'b1, 1'b0, d);
  endtask

  initial begin
    int fv_count;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_frame", 32'(frame_data), 32'd0);
    check("rst_strobe", 32'(ch_strobe), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_err", 32'(sync_err), 32'd0);
    check("rst_ch", 32'(ch_data), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    frame4(4'h1, 4'h2, 4'h3, 4'h4);
    check("t1_frame", 32'(frame_data), 32'h4321);
    drive(1'b0, 1'b0, 4'h0);
    check("t1_fv_drop", 32'(frame_valid), 32'd0);

    fv_count = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, k == 0, 4'($urandom_range(0, 15)));
        check("t2_locked", 32'(locked), 32'd1);
        check("t2_sel", 32'(sel), 32'((k + 1) % 4));
        if (frame_valid) fv_count++;
      end
    end
    check("t2_fv_count", 32'(fv_count), 32'd3);

    frame4(4'h1, 4'h1, 4'h1, 4'h1);
    drive(1'b1, 1'b0, 4'h9);
    check("t5_err", 32'(sync_err), 32'd1);
    check("t5_locked", 32'(locked), 32'd0);
    check("t5_frame_kept", 32'(frame_data), 32'h1111);

    drive(1'b1, 1'b0, 4'h7);
    drive(1'b1, 1'b0, 4'h8);
    drive(1'b1, 1'b0, 4'h9);
    check("t3_hunt_err", 32'(sync_err), 32'd0);
    frame4(4'hA, 4'hB, 4'hC, 4'hD);
    check("t3_frame", 32'(frame_data), 32'hDCBA);

    drive(1'b1, 1'b1, 4'h5);
    drive(1'b1, 1'b0, 4'h6);
    drive(1'b1, 1'b1, 4'h7);
    check("t4_err", 32'(sync_err), 32'd1);
    check("t4_frame_kept", 32'(frame_data), 32'hDCBA);
    drive(1'b1, 1'b0, 4'h8);
    drive(1'b1, 1'b0, 4'h9);
    drive(1'b1, 1'b0, 4'hA);
    check("t4_frame", 32'(frame_data), 32'hA987);

    drive(1'b1, 1'b1, 4'h3);
    drive(1'b0, 1'b0, 4'hF);
    drive(1'b0, 1'b1, 4'hE);
    check("t6_idle_sel", 32'(sel), 32'd1);
    drive(1'b1, 1'b0, 4'h2);
    #3;
    resetn = 1'b0;
    #1;
    check("t6_async_sel", 32'(sel), 32'd0);
    check("t6_async_locked", 32'(locked), 32'd0);
    check("t6_async_frame", 32'(frame_data), 32'd0);
    check("t6_async_strobe", 32'(ch_strobe), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 1'b0, 4'h4);
    check("t6_post_hunt", 32'(ch_strobe), 32'd0);

    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
            4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
